// File: rtl/aes_enc_round_engine.sv
// rtl/aes_enc_round_engine.sv - iterative AES encryption engine, one round per clock
// Optional AES_ENC_PIPE_SBOX_EN: registers SubBytes/ShiftRows output, two cycles per round.
module aes_enc_round_engine #(
  parameter int NR       = 14,
  parameter int RK_IDX_W = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  output logic [RK_IDX_W-1:0] rk_idx,
  input  logic [127:0]        rk,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data,
  output logic                busy
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_enc_round_engine: NR must be 10, 12 or 14");
  end
  if ((1 << RK_IDX_W) <= NR) begin : g_bad_idx_w
    $error("aes_enc_round_engine: RK_IDX_W too narrow for NR");
  end

  localparam logic [RK_IDX_W-1:0] NR_IDX  = RK_IDX_W'(NR);
  localparam logic [RK_IDX_W-1:0] IDX_ONE = RK_IDX_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = gmul(a, a);
    acc = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Byte 4c+r holds s[r][c]; ShiftRows takes s[r][(c+r)%4].
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] t;
    t = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        t[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    return t;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] t;
    logic [7:0]   a0, a1, a2, a3;
    t = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      t[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      t[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      t[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      t[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return t;
  endfunction

  state_e              state_q;
  logic [RK_IDX_W-1:0] rnd_q;
  logic [RK_IDX_W-1:0] rk_idx_q;
  logic [127:0]        blk_q;
  logic [127:0]        out_data_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                busy_q;
  logic [127:0]        sr_d;
  logic [127:0]        round_in;
  logic [127:0]        mix_d;
  logic [127:0]        fin_d;
  logic                round_step;
`ifdef AES_ENC_PIPE_SBOX_EN
  logic [127:0]        sub_q;
  logic                phase_q;
`endif

  always_comb begin
    sr_d = sub_shift(blk_q);
`ifdef AES_ENC_PIPE_SBOX_EN
    round_in   = sub_q;
    round_step = phase_q;
`else
    round_in   = sr_d;
    round_step = 1'b1;
`endif
    mix_d = mix_columns(round_in) ^ rk;
    fin_d = round_in ^ rk;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      rnd_q       <= '0;
      rk_idx_q    <= '0;
      blk_q       <= '0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef AES_ENC_PIPE_SBOX_EN
      sub_q       <= '0;
      phase_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            blk_q      <= in_data ^ rk;
            rnd_q      <= IDX_ONE;
            rk_idx_q   <= IDX_ONE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_ROUND;
`ifdef AES_ENC_PIPE_SBOX_EN
            phase_q    <= 1'b0;
`endif
          end
        end
        S_ROUND: begin
`ifdef AES_ENC_PIPE_SBOX_EN
          phase_q <= ~phase_q;
          if (!phase_q) sub_q <= sr_d;
`endif
          if (round_step) begin
            if (rnd_q == NR_IDX) begin
              blk_q       <= fin_d;
              out_data_q  <= fin_d;
              out_valid_q <= 1'b1;
              rk_idx_q    <= '0;
              state_q     <= S_DONE;
            end else begin
              blk_q    <= mix_d;
              rnd_q    <= rnd_q + IDX_ONE;
              rk_idx_q <= rnd_q + IDX_ONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign rk_idx    = rk_idx_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_aes_enc_round_engine.sv
// tb/tb_aes_enc_round_engine.sv - directed-vector bench for aes_enc_round_engine
// Three engines (NR=10/12/14) fed from bench-expanded key stores.
module tb_aes_enc_round_engine;

`ifdef AES_ENC_PIPE_SBOX_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT10 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         resetn;
  logic [127:0] in_data;
  logic         in_valid_a  [3];
  logic         in_ready_a  [3];
  logic         out_valid_a [3];
  logic         out_ready_a [3];
  logic         busy_a      [3];
  logic [127:0] out_data_a  [3];
  logic [3:0]   rk_idx_a    [3];
  logic [127:0] rk_a        [3];
  logic [127:0] ks          [3][16];
  logic [7:0]   sbox_t      [256];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign rk_a[g] = ks[g][rk_idx_a[g]];
    aes_enc_round_engine #(.NR(10 + 2*g), .RK_IDX_W(4)) u_dut (
      .clk       (clk),
      .resetn    (resetn),
      .in_valid  (in_valid_a[g]),
      .in_ready  (in_ready_a[g]),
      .in_data   (in_data),
      .rk_idx    (rk_idx_a[g]),
      .rk        (rk_a[g]),
      .out_valid (out_valid_a[g]),
      .out_ready (out_ready_a[g]),
      .out_data  (out_data_a[g]),
      .busy      (busy_a[g])
    );
  end

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  task automatic expand_key(input int k, input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = t ^ w[i-nk];
    end
    for (int r = 0; r <= nr; r++) ks[k][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic test_reset();
    resetn  = 1'b0;
    in_data = '0;
    for (int k = 0; k < 3; k++) begin
      in_valid_a[k]  = 1'b0;
      out_ready_a[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({in_ready_a[k], out_valid_a[k], busy_a[k]} !== 3'b100) begin
        bad++;
        $display("FAIL reset_flags dut%0d: got %b want 100", k, {in_ready_a[k], out_valid_a[k], busy_a[k]});
      end
      total++;
      if (rk_idx_a[k] !== 4'd0 || out_data_a[k] !== 128'h0) begin
        bad++;
        $display("FAIL reset_data dut%0d: got idx=%0d data=%h want 0/0", k, rk_idx_a[k], out_data_a[k]);
      end
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_vectors();
    logic [255:0] key_v [3];
    logic [127:0] exp_v [3];
    int cyc;
    key_v[0] = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    key_v[1] = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    key_v[2] = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    exp_v[0] = CT10;
    exp_v[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    exp_v[2] = 128'h8ea2b7ca516745bfeafc49904b496089;
    for (int k = 0; k < 3; k++) begin
      expand_key(k, key_v[k], 4 + 2*k);
      @(negedge clk);
      out_ready_a[k] = 1'b1;
      in_data        = PT;
      in_valid_a[k]  = 1'b1;
      total++;
      if (in_ready_a[k] !== 1'b1) begin
        bad++;
        $display("FAIL vec_in_ready dut%0d: got %b want 1", k, in_ready_a[k]);
      end
      @(negedge clk);
      in_valid_a[k] = 1'b0;
      in_data       = '1;
      cyc = 0;
      while (out_valid_a[k] !== 1'b1 && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      total++;
      if (cyc !== (10 + 2*k) * LAT) begin
        bad++;
        $display("FAIL vec_latency dut%0d: got %0d want %0d", k, cyc, (10 + 2*k) * LAT);
      end
      total++;
      if (out_data_a[k] !== exp_v[k]) begin
        bad++;
        $display("FAIL vec_ct dut%0d: got %h want %h", k, out_data_a[k], exp_v[k]);
      end
      @(negedge clk);
      total++;
      if (out_valid_a[k] !== 1'b0 || in_ready_a[k] !== 1'b1) begin
        bad++;
        $display("FAIL vec_handshake dut%0d: got valid=%b ready=%b want 0/1", k, out_valid_a[k], in_ready_a[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    @(negedge clk);
    out_ready_a[0] = 1'b0;
    in_data        = PT;
    in_valid_a[0]  = 1'b1;
    @(negedge clk);
    in_valid_a[0] = 1'b0;
    cyc = 0;
    while (out_valid_a[0] !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (out_valid_a[0] !== 1'b1 || out_data_a[0] !== CT10) begin
      bad++;
      $display("FAIL bp_first: got valid=%b data=%h want 1/%h", out_valid_a[0], out_data_a[0], CT10);
    end
    in_data       = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    in_valid_a[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (out_valid_a[0] !== 1'b1 || in_ready_a[0] !== 1'b0 || busy_a[0] !== 1'b1 || out_data_a[0] !== CT10) begin
        bad++;
        $display("FAIL bp_hold cyc%0d: got v=%b r=%b b=%b d=%h want 1/0/1/%h",
                 i, out_valid_a[0], in_ready_a[0], busy_a[0], out_data_a[0], CT10);
      end
    end
    out_ready_a[0] = 1'b1;
    in_valid_a[0]  = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid_a[0] !== 1'b0 || in_ready_a[0] !== 1'b1 || busy_a[0] !== 1'b0 || out_data_a[0] !== CT10) begin
      bad++;
      $display("FAIL bp_release: got v=%b r=%b b=%b d=%h want 0/1/0/%h",
               out_valid_a[0], in_ready_a[0], busy_a[0], out_data_a[0], CT10);
    end
    @(negedge clk);
    total++;
    if (busy_a[0] !== 1'b0) begin
      bad++;
      $display("FAIL bp_idle_stays: got busy=%b want 0", busy_a[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] pts [4];
    logic [127:0] cts [4];
    int p, nin, nout, rk_bad, j, exp_idx;
    pts[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
    pts[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    pts[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    pts[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;
    cts[0] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    cts[1] = 128'hf5d3d58503b9699de785895a96fdbaaf;
    cts[2] = 128'h43b1cd7f598ece23881b00e3ed030688;
    cts[3] = 128'h7b0c785e27e8ad3f8223207104725dd4;
    expand_key(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
    p = 10 * LAT + 2;
    nin = 0;
    nout = 0;
    rk_bad = 0;
    out_ready_a[0] = 1'b1;
    for (int t = 0; t < 4*p + 4; t++) begin
      @(negedge clk);
      if (t < 4*p) begin
        j = t % p;
        exp_idx = (j == 0 || j == p - 1) ? 0 : (j - 1) / LAT + 1;
        if (rk_idx_a[0] !== 4'(exp_idx)) rk_bad++;
      end
      if (out_valid_a[0] === 1'b1) begin
        total++;
        if (nout >= 4) begin
          bad++;
          $display("FAIL b2b_extra_out: got output %0d want at most 4", nout + 1);
        end else begin
          if (out_data_a[0] !== cts[nout]) begin
            bad++;
            $display("FAIL b2b_ct%0d: got %h want %h", nout, out_data_a[0], cts[nout]);
          end
          total++;
          if (t !== nout * p + p - 1) begin
            bad++;
            $display("FAIL b2b_spacing%0d: got cycle %0d want %0d", nout, t, nout * p + p - 1);
          end
        end
        nout++;
      end
      if (in_ready_a[0] === 1'b1 && nin < 4) begin
        in_data       = pts[nin];
        in_valid_a[0] = 1'b1;
        nin++;
      end else if (nin == 4) begin
        in_valid_a[0] = 1'b0;
      end
    end
    total++;
    if (rk_bad !== 0) begin
      bad++;
      $display("FAIL b2b_rk_idx_seq: got %0d wrong indices want 0", rk_bad);
    end
    total++;
    if (nout !== 4) begin
      bad++;
      $display("FAIL b2b_count: got %0d outputs want 4", nout);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int seen;
    expand_key(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    @(negedge clk);
    out_ready_a[0] = 1'b1;
    in_data        = PT;
    in_valid_a[0]  = 1'b1;
    @(negedge clk);
    in_valid_a[0] = 1'b0;
    cyc = 0;
    while (rk_idx_a[0] !== 4'd5 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (rk_idx_a[0] !== 4'd5 || busy_a[0] !== 1'b1) begin
      bad++;
      $display("FAIL rst_reach_round5: got idx=%0d busy=%b want 5/1", rk_idx_a[0], busy_a[0]);
    end
    #2 resetn = 1'b0;
    #1;
    total++;
    if ({in_ready_a[0], out_valid_a[0], busy_a[0]} !== 3'b100 || rk_idx_a[0] !== 4'd0 || out_data_a[0] !== 128'h0) begin
      bad++;
      $display("FAIL rst_async: got r=%b v=%b b=%b idx=%0d d=%h want 1/0/0/0/0",
               in_ready_a[0], out_valid_a[0], busy_a[0], rk_idx_a[0], out_data_a[0]);
    end
    @(negedge clk);
    resetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 3 * (10 * LAT + 2); i++) begin
      @(negedge clk);
      if (out_valid_a[0] === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL rst_no_output: got %0d valid cycles want 0", seen);
    end
    in_data       = PT;
    in_valid_a[0] = 1'b1;
    @(negedge clk);
    in_valid_a[0] = 1'b0;
    cyc = 0;
    while (out_valid_a[0] !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (cyc !== 10 * LAT || out_data_a[0] !== CT10) begin
      bad++;
      $display("FAIL rst_next_block: got lat=%0d d=%h want %0d/%h", cyc, out_data_a[0], 10 * LAT, CT10);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [2047:0] tbl;
    tbl = {128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
           128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
           128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
           128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
           128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
           128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
           128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
           128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    for (int i = 0; i < 256; i++) sbox_t[i] = tbl[2047-8*i -: 8];
    test_reset();
    test_vectors();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_enc_round_engine.md
# aes_enc_round_engine

Iterative AES encryption datapath performing one full round (SubBytes, ShiftRows, MixColumns, AddRoundKey) per clock, parametrised by round count so one RTL serves AES-128, AES-192 and AES-256. It sits between the block-input buffering and the output register stage of the encryption top. It pulls round keys from an external key-schedule store through an index/data port, and exchanges 128-bit blocks through valid/ready handshakes.

## Interface
- NR, 14: number of rounds. Legal values are 10, 12 and 14; any other value is a `$error` at elaboration.
- RK_IDX_W, 4: width of the round-key index. Must satisfy 2^RK_IDX_W > NR.
- clk  in  1  clock, all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  input block valid.
- in_ready  out  1  engine can accept a block.
- in_data  in  128  plaintext. in_data[127:120] is byte 0. State byte s[r][c] = byte 4c+r.
- rk_idx  out  RK_IDX_W  round-key index requested this cycle.
- rk  in  128  round key for rk_idx. Combinational, valid in the same cycle. Same byte order as in_data.
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  downstream accepts ciphertext.
- out_data  out  128  ciphertext, same byte order.
- busy  out  1  high in every state except IDLE.

## Operation
- The FSM has three states: IDLE, ROUND and DONE. Reset state is IDLE.
- **IDLE**
  - in_ready=1 and rk_idx=0.
  - On in_valid: state <= in_data ^ rk (initial AddRoundKey), round counter rnd <= 1, go to ROUND.
- **ROUND**
  - rk_idx=rnd.
  - When rnd<NR: state <= MixColumns(ShiftRows(SubBytes(state))) ^ rk, then rnd <= rnd+1.
  - When rnd==NR: MixColumns is omitted, state <= ShiftRows(SubBytes(state)) ^ rk, go to DONE.
- **DONE**
  - out_valid=1 and out_data=state.
  - On out_ready: go to IDLE.
  - The engine does not accept a new block in the same cycle as the output handshake.
- **S-box:** 16 parallel combinational instances, built as GF(2^8) inverse over modulus 0x11B followed by the FIPS-197 affine transform with constant 0x63. Inverse of 0x00 is defined as 0x00.
- **MixColumns:** xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0x00). All arithmetic is 8-bit, with no carries leaving a byte.
- **Data signals:** in_data and rk are sampled only on the edges described above. in_data is ignored outside IDLE.
- **Output stability:** out_data holds the last ciphertext until the next block is accepted. It holds its previous value in IDLE.
- **Reset mid-operation:** asserting resetn=0 at any time returns the FSM to IDLE immediately and asynchronously. The in-flight block is discarded and produces no output.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, rk_idx=0, out_data=128'h0, rnd=0.
- Latency: if a block is accepted at edge 0, out_valid rises after edge NR, i.e. NR cycles later.
- Throughput: one block per NR+2 cycles with out_ready held high.
- Backpressure: while out_valid=1 and out_ready=0, out_valid and out_data hold. in_ready stays 0.
- rk_idx is a registered decode of state/rnd. The key store must return rk combinationally within the same cycle.
- All outputs are driven from registers. There are no combinational paths from in_valid or out_ready to any output.

## Configuration
- AES_ENC_PIPE_SBOX_EN
  - **Defined:**
    - A 128-bit register is inserted after SubBytes, so each round takes two cycles: a SUB phase then a MIX phase.
    - rk_idx=rnd is held for both phases; rk is consumed only in the MIX phase.
    - Latency becomes 2·NR cycles.
  - **Undefined:** one cycle per round, as described above.

## Test plan
- NR=10, key 000102…0f expanded by the bench model, pt 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a with out_valid after exactly 10 cycles.
- NR=12, key 000102…17, same pt -> dda97ca4864cdfe06eaf70a0ec0d7191. NR=14, key 000102…1f -> 8ea2b7ca516745bfeafc49904b496089.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0 and in_valid ignored. Release -> IDLE on the next cycle.
- Back-to-back: 4 NIST blocks with in_valid and out_ready held high -> 4 correct ciphertexts at a spacing of NR+2 cycles. rk_idx sequence 0,1..NR repeats.
- Reset at round 5 -> outputs return to reset values immediately and no out_valid pulse occurs. The next block encrypts correctly.
- With AES_ENC_PIPE_SBOX_EN: repeat the first three scenarios and check that latency is 2·NR cycles and results are identical.
